eq_button_ctrl: RTL

User-interface controller for the equalizer front panel. Consumes single-cycle, already-synchronized button-release pulses (NEXT, PREV, UP, DOWN) and arbitrates simultaneous presses by fixed priority. It maintains a selected-band index and a per-band gain table, and issues gain-update writes to the equalizer datapath over a req/ack handshake. A post-event lockout window suppresses rapid repeat presses.

---
 rtl/eq_button_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/eq_button_ctrl.sv
// Equalizer front-panel controller: prioritized button events, band select, saturating gain table, req/ack write-out.
// Optional build macro EQ_BTN_PENDING_EN adds a one-deep pending event captured while busy.
module eq_button_ctrl #(
  parameter int NUM_BANDS    = 5,
  parameter int BAND_W       = 3,
  parameter int GAIN_W       = 4,
  parameter int GAIN_MAX     = 15,
  parameter int GAIN_DEFAULT = 8,
  parameter int LOCK_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rel_next,
  input  logic              rel_prev,
  input  logic              rel_up,
  input  logic              rel_down,
  output logic [BAND_W-1:0] band_sel,
  output logic [GAIN_W-1:0] gain_cur,
  output logic              gain_wr_req,
  output logic [BAND_W-1:0] gain_wr_band,
  output logic [GAIN_W-1:0] gain_wr_val,
  input  logic              gain_wr_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, LOCKOUT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  lock_cnt;
  logic [GAIN_W-1:0] gains [NUM_BANDS];

  logic [3:0]        raw;
  logic [3:0]        ev;
  logic [BAND_W-1:0] band_inc;
  logic [BAND_W-1:0] band_dec;
  logic [GAIN_W-1:0] gain_inc;
  logic [GAIN_W-1:0] gain_dec;
  logic              up_ok;
  logic              dn_ok;

  // One-hot of the highest-priority bit: {next, prev, up, down}.
  function automatic logic [3:0] pick(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else if (v[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  assign raw = {rel_next, rel_prev, rel_up, rel_down};

`ifdef EQ_BTN_PENDING_EN
  logic [3:0] pend;
  logic [3:0] raw_pick;
  assign raw_pick = pick(raw);
  // A held event competes with fresh pulses in the first IDLE cycle.
  assign ev = pick(raw | pend);
`else
  assign ev = pick(raw);
`endif

  assign gain_cur = gains[band_sel];
  assign band_inc = (band_sel == BAND_W'(NUM_BANDS - 1)) ? '0 : band_sel + 1'b1;
  assign band_dec = (band_sel == '0) ? BAND_W'(NUM_BANDS - 1) : band_sel - 1'b1;
  assign up_ok    = (gain_cur != GAIN_W'(GAIN_MAX));
  assign dn_ok    = (gain_cur != '0);
  assign gain_inc = gain_cur + 1'b1;
  assign gain_dec = gain_cur - 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      band_sel     <= '0;
      gain_wr_req  <= 1'b0;
      gain_wr_band <= '0;
      gain_wr_val  <= '0;
      lock_cnt     <= '0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) gains[i] <= GAIN_W'(GAIN_DEFAULT);
`ifdef EQ_BTN_PENDING_EN
      pend         <= '0;
`endif
    end else begin
`ifdef EQ_BTN_PENDING_EN
      if (state == IDLE)       pend <= '0;
      else if (raw_pick > pend) pend <= raw_pick;
`endif
      case (state)
        IDLE: begin
          if (ev[3]) begin
            band_sel <= band_inc;
            state    <= LOCKOUT;
            lock_cnt <= CNT_W'(LOCK_CYCLES);
          end else if (ev[2]) begin
            band_sel <= band_dec;
            state    <= LOCKOUT;
            lock_cnt <= CNT_W'(LOCK_CYCLES);
          end else if ((ev[1] && up_ok) || (ev[0] && dn_ok)) begin
            gains[band_sel] <= ev[1] ? gain_inc : gain_dec;
            gain_wr_req     <= 1'b1;
            gain_wr_band    <= band_sel;
            gain_wr_val     <= ev[1] ? gain_inc : gain_dec;
            state           <= WRITE;
          end else if (ev[1] || ev[0]) begin
            state    <= LOCKOUT;
            lock_cnt <= CNT_W'(LOCK_CYCLES);
          end
        end
        WRITE: begin
          if (gain_wr_ack) begin
            gain_wr_req <= 1'b0;
            state       <= LOCKOUT;
            lock_cnt    <= CNT_W'(LOCK_CYCLES);
          end
        end
        LOCKOUT: begin
          lock_cnt <= lock_cnt - 1'b1;
          if (lock_cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
